// File: rtl/slac_pkg.sv
// Shared types and constants for the scratchpad read streamer.
package slac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/spad_read_streamer_if.sv
// Control, scratchpad and output-stream signals of the read streamer.
interface spad_read_streamer_if #(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned ADDR_BITWIDTH = 9
);

  logic                     i_start;
  logic [ADDR_BITWIDTH-1:0] i_base_addr;
  logic [ADDR_BITWIDTH:0]   i_len;
  logic                     o_busy;
  logic                     o_done;
  logic                     o_spad_ren;
  logic [ADDR_BITWIDTH-1:0] o_spad_raddr;
  logic [DATA_BITWIDTH-1:0] i_spad_rdata;
  logic                     o_valid;
  logic                     i_ready;
  logic [DATA_BITWIDTH-1:0] o_data;

  modport master (
    input  i_start, i_base_addr, i_len, i_spad_rdata, i_ready,
    output o_busy, o_done, o_spad_ren, o_spad_raddr, o_valid, o_data
  );

  modport slave (
    output i_start, i_base_addr, i_len, i_spad_rdata, i_ready,
    input  o_busy, o_done, o_spad_ren, o_spad_raddr, o_valid, o_data
  );

endinterface

// File: rtl/skid_fifo2.sv
// Two-entry FIFO; an incoming word is presented directly when the FIFO is empty.
module skid_fifo2
  import slac_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [DATA_BITWIDTH-1:0] i_data,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [DATA_BITWIDTH-1:0] o_data,
  output logic [1:0]               o_count
);

  logic [DATA_BITWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITWIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                     wr_ptr_q, wr_ptr_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic [1:0]               count_q, count_d;
  logic                     empty, pop, store, deq;

  always_comb begin
    empty    = (count_q == 2'd0);
    o_valid  = !empty || i_push;
    // Stored head wins; the bypass only applies to a word landing in an empty FIFO.
    o_data   = (empty && i_push) ? i_data : mem_q[rd_ptr_q];
    pop      = o_valid && i_ready;
    store    = i_push && !(empty && pop);
    deq      = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (store) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (deq) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + 2'(store) - 2'(deq);
  end

  assign o_count = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/spad_read_streamer.sv
// Streams a contiguous scratchpad range out through a valid/ready port.
module spad_read_streamer
  import slac_pkg::*;
#(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned ADDR_BITWIDTH = 9
) (
  input  logic                clk,
  input  logic                reset,
  spad_read_streamer_if.master bus
);

  state_e                   state_q, state_d;
  logic [ADDR_BITWIDTH-1:0] addr_q, addr_d;
  logic [ADDR_BITWIDTH:0]   rem_q, rem_d;
  logic                     ren_q, ren_d;
  logic [ADDR_BITWIDTH-1:0] raddr_q, raddr_d;
  logic                     inflight_q, inflight_d;
  logic                     done_q, done_d;

  logic                     fifo_valid;
  logic [DATA_BITWIDTH-1:0] fifo_data;
  logic [1:0]               fifo_count;
  logic                     pop;
  logic [2:0]               occ;
  logic                     can_issue;

  skid_fifo2 #(.DATA_BITWIDTH(DATA_BITWIDTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (inflight_q),
    .i_data  (bus.i_spad_rdata),
    .i_ready (bus.i_ready),
    .o_valid (fifo_valid),
    .o_data  (fifo_data),
    .o_count (fifo_count)
  );

  // Words owed to the consumer: stored, landing now, and issued to the scratchpad.
  assign pop       = fifo_valid && bus.i_ready;
  assign occ       = 3'(fifo_count) + 3'(inflight_q) + 3'(ren_q);
  assign can_issue = (occ < (3'd2 + 3'(pop)));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    ren_d      = 1'b0;
    raddr_d    = raddr_q;
    inflight_d = ren_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_len != '0) begin
            addr_d  = bus.i_base_addr;
            rem_d   = bus.i_len;
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (can_issue) begin
          ren_d   = 1'b1;
          raddr_d = addr_q;
          addr_d  = addr_q + ADDR_BITWIDTH'(1);
          rem_d   = rem_q - (ADDR_BITWIDTH + 1)'(1);
          if (rem_q == (ADDR_BITWIDTH + 1)'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && (occ == 3'd1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      ren_q      <= 1'b0;
      raddr_q    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      ren_q      <= ren_d;
      raddr_q    <= raddr_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_done       = done_q;
  assign bus.o_spad_ren   = ren_q;
  assign bus.o_spad_raddr = raddr_q;
  assign bus.o_valid      = fifo_valid;
  assign bus.o_data       = fifo_data;

endmodule

// File: doc/spad_read_streamer.md
SPAD_READ_STREAMER -- requirements
Module: spad_read_streamer

Interface
REQ-001 SHALL have parameter DATA_BITWIDTH, default 16, word width of the scratchpad.
REQ-002 SHALL have parameter ADDR_BITWIDTH, default 9, scratchpad address width (depth 2^ADDR_BITWIDTH).
REQ-003 SHALL have one clock and a synchronous, active-high reset; clk is the clock port and reset is the reset port.
REQ-004 SHALL have the following ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_start  in  1  start request pulse
- i_base_addr  in  ADDR_BITWIDTH  first read address
- i_len  in  ADDR_BITWIDTH+1  word count, 0..2^ADDR_BITWIDTH
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle completion pulse
- o_spad_ren  out  1  scratchpad read enable
- o_spad_raddr  out  ADDR_BITWIDTH  scratchpad read address
- i_spad_rdata  in  DATA_BITWIDTH  scratchpad read data, valid one cycle after o_spad_ren
- o_valid  out  1  output word valid
- i_ready  in  1  consumer ready
- o_data  out  DATA_BITWIDTH  output word

Function
REQ-005 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-006 In IDLE, i_start with i_len>0 SHALL latch base and length and go to RUN next cycle.
REQ-007 In IDLE, i_start with i_len=0 SHALL go nowhere and pulse o_done next cycle, with no reads issued.
REQ-008 i_start outside IDLE SHALL be ignored.
REQ-009 In RUN, a read SHALL issue (o_spad_ren=1) when (buffer count + in-flight - pop) < 2, where pop = o_valid & i_ready.
REQ-010 Read addresses SHALL be base, base+1, ..., incremented modulo 2^ADDR_BITWIDTH (wrap 511->0 at default).
REQ-011 o_spad_ren and o_spad_raddr SHALL be registered outputs.
REQ-012 i_spad_rdata SHALL be captured only in the cycle after an issued read.
REQ-013 Data arriving outside that cycle SHALL be ignored, since the scratchpad returns 0 when not enabled.
REQ-014 Captured words SHALL enter a 2-entry FIFO; o_valid/o_data SHALL present the FIFO head.
REQ-015 Word order SHALL equal address order; no word SHALL be dropped or duplicated.
REQ-016 Handshake: a word transfers when o_valid & i_ready.
REQ-017 Once asserted, o_valid and o_data SHALL stay stable until the transfer.
REQ-018 Simultaneous push and pop SHALL keep the FIFO count unchanged.
REQ-019 With i_ready held high, throughput SHALL be one word per cycle after first-word latency.
REQ-020 First-word latency: o_valid SHALL rise 3 cycles after the i_start cycle.
REQ-021 After the last read issues, the FSM SHALL go RUN->DRAIN.
REQ-022 DRAIN SHALL go to IDLE in the cycle the final word transfers.
REQ-023 o_done SHALL pulse for exactly one cycle, the cycle after the final transfer.
REQ-024 o_busy SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-025 The read counter SHALL be ADDR_BITWIDTH+1 bits wide so that i_len=2^ADDR_BITWIDTH is reachable.

Reset
REQ-026 Reset SHALL force state IDLE and FIFO count 0, and clear the in-flight flag.
REQ-027 Reset SHALL force o_busy, o_done, o_spad_ren, o_valid, o_data and o_spad_raddr to 0.
REQ-028 Reset mid-transfer SHALL abandon the transfer with no o_done pulse.
REQ-029 The read returning in the cycle after reset SHALL be discarded.

Structure
REQ-030 The FSM state enum and FIFO depth constant (2) SHALL live in shared package slac_pkg.
REQ-031 The 2-entry FIFO SHALL be a sub-module, skid_fifo2, parameterised by DATA_BITWIDTH.
REQ-032 The block SHALL connect directly to SPad ports i_ren, i_raddr and o_rdata.

Verification
REQ-033 Bench SHALL cover this scenario: base=0, len=4, mem[k]=k+100, i_ready=1 -> o_data 100,101,102,103 on consecutive cycles, o_done pulse one cycle after the last.
REQ-034 Bench SHALL cover this scenario: base=510, len=4 -> addresses 510,511,0,1 in order.
REQ-035 Bench SHALL cover this scenario: len=8 with i_ready toggling 1,0,0,1,... -> all 8 words in order, o_data stable while stalled, FIFO never overflows.
REQ-036 Bench SHALL cover this scenario: len=0 -> zero reads and o_valid never high, o_done at cycle+1.
REQ-037 Bench SHALL cover this scenario: len=512 -> 512 words, o_busy high throughout.
REQ-038 Bench SHALL cover this scenario: i_start again while busy -> ignored.
REQ-039 Bench SHALL cover this scenario: reset asserted on the 3rd output word of len=6 -> all outputs 0 next cycle, no o_done, and a new start succeeds.
